// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: queue entry layout and
// the fetch control state.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic        fault;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        RUN,
        FAULT,
        HALT
    } fetch_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous in-order queue between instruction memory and decode.
// Flush empties it in one cycle; push and pop may coincide at any level.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type entry_t = fetch_entry_t,
    parameter int  CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  entry_t        push_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output logic [CW-1:0] count_o,
    output entry_t        head_o,
    output logic          valid_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] rd_q;
    logic [PW-1:0] wr_q;
    logic [CW-1:0] count_q;
    logic          do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop = pop_i && (count_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= push_data_i;
                wr_q        <= bump(wr_q);
            end
            if (do_pop) begin
                rd_q <= bump(rd_q);
            end
            count_q <= count_q + CW'(push_i) - CW'(do_pop);
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_q];
    assign valid_o = (count_q != '0);

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, issues credit-limited word requests,
// queues in-order responses for decode and handles execute redirects.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_instruction,
    output logic        fetch_fault
);

    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    fetch_state_t  state_q, state_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [31:0]   fault_pc_q, fault_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    logic          live_q;

    logic          accept;
    logic          fifo_push;
    fetch_entry_t  fifo_push_data;
    logic          fifo_pop;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  fifo_head;
    logic          fifo_valid;

    // live_q keeps the request port quiet for the first cycle after reset
    assign imem_req_valid = live_q && (state_q == RUN) && !redirect_valid &&
                            (({1'b0, outstanding_q} + {1'b0, fifo_count}) < DEPTH_W);
    assign imem_req_addr  = req_pc_q;
    assign accept         = imem_req_valid && imem_req_ready;
    assign fifo_pop       = fifo_valid && fetch_ready && !redirect_valid;

    always_comb begin
        state_d        = state_q;
        req_pc_d       = req_pc_q;
        resp_pc_d      = resp_pc_q;
        fault_pc_d     = fault_pc_q;
        drop_d         = drop_q;
        fifo_push      = 1'b0;
        fifo_push_data = '0;
        outstanding_d  = outstanding_q + CW'(accept) - CW'(imem_resp_valid);

        if (redirect_valid) begin
            drop_d = outstanding_d;
            if (redirect_pc[1:0] == 2'b00) begin
                state_d   = RUN;
                req_pc_d  = redirect_pc;
                resp_pc_d = redirect_pc;
            end else begin
                state_d    = FAULT;
                fault_pc_d = redirect_pc;
            end
        end else begin
            if (accept) begin
                req_pc_d = req_pc_q + PC_STEP;
            end
            if (imem_resp_valid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - 1'b1;
                end else begin
                    fifo_push      = 1'b1;
                    fifo_push_data = '{pc: resp_pc_q, instruction: imem_resp_data, fault: 1'b0};
                    resp_pc_d      = resp_pc_q + PC_STEP;
                end
            end
            // The fault entry goes out only once every stale response has drained
            if ((state_q == FAULT) && (drop_q == '0) && (fifo_count == '0)) begin
                fifo_push      = 1'b1;
                fifo_push_data = '{pc: fault_pc_q, instruction: 32'h0, fault: 1'b1};
                state_d        = HALT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            req_pc_q      <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            fault_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            live_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_pc_q      <= req_pc_d;
            resp_pc_q     <= resp_pc_d;
            fault_pc_q    <= fault_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            live_q        <= 1'b1;
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t),
        .CW      (CW)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i (fifo_push_data),
        .pop_i       (fifo_pop),
        .flush_i     (redirect_valid),
        .count_o     (fifo_count),
        .head_o      (fifo_head),
        .valid_o     (fifo_valid)
    );

    assign fetch_valid       = fifo_valid;
    assign fetch_pc          = fifo_valid ? fifo_head.pc : '0;
    assign fetch_instruction = fifo_valid ? fifo_head.instruction : '0;
    assign fetch_fault       = fifo_valid && fifo_head.fault;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for the fetch stage: an in-order memory model with
// variable latency plus an architectural model of the expected PC stream.
module tb_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] MAGIC    = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fetch_valid;
    logic        fetch_ready = 1'b1;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_instruction;
    logic        fetch_fault;

    int errors = 0;
    int checks = 0;

    fetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .imem_req_valid    (imem_req_valid),
        .imem_req_ready    (imem_req_ready),
        .imem_req_addr     (imem_req_addr),
        .imem_resp_valid   (imem_resp_valid),
        .imem_resp_data    (imem_resp_data),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .fetch_valid       (fetch_valid),
        .fetch_ready       (fetch_ready),
        .fetch_pc          (fetch_pc),
        .fetch_instruction (fetch_instruction),
        .fetch_fault       (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // In-order instruction memory: each accepted request returns addr^MAGIC
    // after a latency drawn from [latMin, latMax], one response per cycle.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t pending[$];
    int    cyc = 0;
    int    latMin = 1;
    int    latMax = 1;
    bit    randReady = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            pending.delete();
        end else begin
            if (imem_resp_valid) void'(pending.pop_front());
            if (imem_req_valid && imem_req_ready)
                pending.push_back('{imem_req_addr, cyc + int'($urandom_range(latMax, latMin))});
            checkOutput("credit_cap", 32'(pending.size() > DEPTH), 32'd0);
        end
        #1;
        if (rst_n && pending.size() > 0 && pending[0].due <= cyc + 1) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = pending[0].addr ^ MAGIC;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        imem_req_ready = randReady ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Architectural model: mode 0 streams sequential PCs, mode 1 expects a
    // single fault entry, mode 2 is halted until the next redirect.
    logic [31:0] expPc = RESET_PC;
    logic [31:0] faultPc = '0;
    int          mode = 0;
    int          pops = 0;

    always @(posedge clk) begin
        if (rst_n) begin
            if (mode != 0) checkOutput("no_req_when_stopped", 32'(imem_req_valid), 32'd0);
            if (mode == 2) checkOutput("halt_empty", 32'(fetch_valid), 32'd0);
            if (imem_req_valid) checkOutput("req_aligned", 32'(imem_req_addr[1:0]), 32'd0);
        end
        if (!rst_n) begin
            expPc = RESET_PC;
            mode  = 0;
        end else if (redirect_valid) begin
            if (redirect_pc[1:0] == 2'b00) begin
                expPc = redirect_pc;
                mode  = 0;
            end else begin
                faultPc = redirect_pc;
                mode    = 1;
            end
        end else if (fetch_valid && fetch_ready) begin
            pops++;
            if (mode == 1) begin
                checkOutput("fault_pc", fetch_pc, faultPc);
                checkOutput("fault_instr", fetch_instruction, 32'h0);
                checkOutput("fault_flag", 32'(fetch_fault), 32'd1);
                mode = 2;
            end else if (mode == 0) begin
                checkOutput("stream_pc", fetch_pc, expPc);
                checkOutput("stream_instr", fetch_instruction, expPc ^ MAGIC);
                checkOutput("stream_fault", 32'(fetch_fault), 32'd0);
                expPc = expPc + 32'd4;
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic applyReset(input bit readyAfter);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        fetch_ready    = readyAfter;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic waitValid(input string name, input int bound);
        for (int i = 0; i < bound && !fetch_valid; i++) step();
        checkOutput(name, 32'(fetch_valid), 32'd1);
    endtask

    task automatic pulseRedirect(input logic [31:0] target);
        redirect_pc    = target;
        redirect_valid = 1'b1;
        step();
        redirect_valid = 1'b0;
    endtask

    typedef struct {
        logic [31:0] target;
        int          lat;
        logic [31:0] expPc;
        logic [31:0] expInstr;
        logic        expFault;
    } vec_t;

    vec_t vecs[6];

    task automatic applyStimulus(input vec_t v);
        latMin = v.lat;
        latMax = v.lat;
        fetch_ready = 1'b1;
        step(7);
        pulseRedirect(v.target);
        waitValid("vec_valid", 40);
        checkOutput("vec_pc", fetch_pc, v.expPc);
        checkOutput("vec_instr", fetch_instruction, v.expInstr);
        checkOutput("vec_fault", 32'(fetch_fault), 32'(v.expFault));
        step(10);
    endtask

    initial begin
        int startPops;
        bit found;

        vecs[0] = '{32'h0000_0400, 3, 32'h0000_0400, 32'hA5A5_0400, 1'b0};
        vecs[1] = '{32'h0000_0800, 1, 32'h0000_0800, 32'hA5A5_0800, 1'b0};
        vecs[2] = '{32'h0000_0202, 2, 32'h0000_0202, 32'h0000_0000, 1'b1};
        vecs[3] = '{32'h0000_0300, 1, 32'h0000_0300, 32'hA5A5_0300, 1'b0};
        vecs[4] = '{32'h0000_1001, 3, 32'h0000_1001, 32'h0000_0000, 1'b1};
        vecs[5] = '{32'h0000_2000, 2, 32'h0000_2000, 32'hA5A5_2000, 1'b0};

        // Reset values while rst_n is held low
        rst_n = 1'b0;
        step(2);
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("rst_req_addr", imem_req_addr, RESET_PC);
        checkOutput("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        checkOutput("rst_fetch_pc", fetch_pc, 32'h0);
        checkOutput("rst_fetch_instr", fetch_instruction, 32'h0);
        checkOutput("rst_fetch_fault", 32'(fetch_fault), 32'd0);

        // Streaming with latency 1 and decode always ready
        applyReset(1'b1);
        startPops = pops;
        step(40);
        checkOutput("stream_progress", 32'((pops - startPops) >= 20), 32'd1);

        // Decode stall right after reset: head holds the first instruction
        applyReset(1'b0);
        waitValid("stall_valid", 20);
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("stall_hold_pc", fetch_pc, RESET_PC);
            checkOutput("stall_hold_valid", 32'(fetch_valid), 32'd1);
        end
        fetch_ready = 1'b1;
        step(12);

        // Redirect coinciding with a response arrival and a decode pop
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (fetch_valid && imem_resp_valid) found = 1'b1;
            else step();
        end
        checkOutput("coincide_found", 32'(found), 32'd1);
        pulseRedirect(32'h0000_0500);
        checkOutput("coincide_flushed", 32'(fetch_valid), 32'd0);
        waitValid("coincide_valid", 20);
        checkOutput("coincide_pc", fetch_pc, 32'h0000_0500);
        checkOutput("coincide_instr", fetch_instruction, 32'h0000_0500 ^ MAGIC);
        step(6);

        // Table of redirects under different memory latencies
        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Randomized traffic against the model
        latMin    = 1;
        latMax    = 4;
        randReady = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            fetch_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) begin
                if ($urandom_range(0, 7) == 0)
                    redirect_pc = {18'h0, 12'($urandom_range(0, 4095)), 2'($urandom_range(1, 3))};
                else
                    redirect_pc = {18'h0, 12'($urandom_range(0, 4095)), 2'b00};
                redirect_valid = 1'b1;
            end else begin
                redirect_valid = 1'b0;
            end
            step();
        end
        redirect_valid = 1'b0;
        randReady      = 1'b0;
        latMin         = 1;
        latMax         = 1;
        fetch_ready    = 1'b1;
        pulseRedirect(32'h0000_0600);
        step(8);

        // Asynchronous reset mid-stream
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_fetch_valid", 32'(fetch_valid), 32'd0);
        checkOutput("async_req_valid", 32'(imem_req_valid), 32'd0);
        step(2);
        rst_n = 1'b1;
        waitValid("restart_valid", 20);
        checkOutput("restart_pc", fetch_pc, RESET_PC);
        checkOutput("restart_instr", fetch_instruction, RESET_PC ^ MAGIC);
        step(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
